iir_sos_cascade: RTL and testbench
==================================

Name: iir_sos_cascade

Overview:
Parametrised, time-multiplexed cascade of NSEC second-order IIR sections (transposed direct form II), generalising the single fixed 16-bit biquad.
- One shared multiplier and one accumulator.
- Coefficient register file and per-section delay state live inside the block.
- Sits between sample source and DAC/output path; a valid/ready sample handshake replaces the free-running per-clock update.

Parameters:
DW, 16, sample width (signed in/out)
CW, 16, coefficient width (signed, Q(CW-FRAC-1).FRAC)
FRAC, 14, coefficient fractional bits
ACCW, 36, accumulator/delay-state width
NSEC, 4, number of cascaded sections (1..16)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block idle, can accept sample
in_data  in  DW  signed input sample
out_valid  out  1  one-cycle pulse, out_data new
out_data  out  DW  signed filtered sample, held until next result
cfg_we  in  1  coefficient write strobe
cfg_ready  out  1  coefficient write accepted this cycle (= in_ready)
cfg_addr  in  clog2(5*NSEC)  index = 5*section + k; k: 0=b0,1=b1,2=b2,3=a1,4=a2
cfg_data  in  CW  signed coefficient
state_clr  in  1  zero all delay states (honoured only when idle)

Behaviour:
- Reset: RST low at a rising edge produces the following state:
  - FSM IDLE; in_ready=1; out_valid=0; out_data=0.
  - All delay states 0.
  - Coefficients b0 = 1<<FRAC, all others 0, giving unity pass-through.
  - Reset mid-computation aborts the sample; no out_valid is produced.
- Section equations, per sample, x = section input:
  - y = sat(acc >> FRAC), where acc = x*b0 + z1.
  - z1' = x*b1 + y*a1 + z2.
  - z2' = x*b2 + y*a2.
  - a-terms are ADDED: coefficients are stored pre-negated.
  - y of section s is x of section s+1; the last y goes to out_data.
- Arithmetic:
  - Products are full DW+CW signed.
  - acc and z are ACCW signed with FRAC fractional bits; sums wrap at ACCW, with no internal saturation.
  - >>FRAC is an arithmetic shift (floor).
  - sat clamps to [-2^(DW-1), 2^(DW-1)-1].
- FSM: IDLE -> S_B0 -> S_B1 -> S_B2 -> S_A1 -> S_A2 -> (next section S_B0 | DONE) -> IDLE.
  - One multiply per state.
  - y is formed in S_B0 and registered for S_A1/S_A2.
  - z1/z2 of the section are written in S_A1/S_A2.
- Timing:
  - Handshake at edge T (in_valid & in_ready) latches in_data and leaves IDLE.
  - Compute runs 5*NSEC cycles.
  - out_valid is high during cycle T+5*NSEC+1 (DONE), with out_data updated the same cycle.
  - in_ready returns to 1 in the cycle after DONE.
  - Throughput: one sample per 5*NSEC+2 cycles.
- in_ready=0 whenever not IDLE; in_valid is ignored then, and the source holds data.
- Configuration writes:
  - cfg_we is accepted only when cfg_ready=1; it writes cfg_data to cfg_addr at the edge.
  - Writes while busy are dropped; the source must wait for cfg_ready.
  - cfg_addr >= 5*NSEC is ignored.
- Simultaneous events in IDLE:
  - Sample handshake plus cfg write: the write applies first, and the new coefficient is used by that sample.
  - state_clr plus handshake: states are cleared, and the sample starts from zero state.
  - state_clr while busy is ignored.

Decomposition:
- Shared package iir_sos_pkg holds:
  - FSM state enum.
  - Coefficient index constants K_B0..K_A2 and COEF_PER_SEC=5.
  - Saturating-truncate function.
- One natural sub-module: sos_sat_trunc (ACCW -> DW shift-by-FRAC with clamp), reused for the inter-section and output paths.
- Coefficient file and delay-state arrays are plain register arrays inside the top.

Test Plan:
1. After reset, NSEC=4, send 1000 -> out_data=1000 with out_valid exactly 21 cycles after the handshake; in_ready low for those cycles.
2. Section 0 b0=8192 (0.5), send 1000 then -1001 -> 500, then -501 (floor).
3. Section 0 b0=24576 (1.5), send 30000 then -30000 -> 32767, then -32768 (saturation).
4. Section 0 b0=16384, a1=8192 (pole +0.5 stored), impulse 16384 then zeros -> 16384, 8192, 4096, 2048; then state_clr in IDLE, send 0 -> 0.
5. Section 0 b0=0, b1=16384 (unit delay), sections 1-3 default, impulse 5000 then zeros -> 0, 5000, 0.
6. cfg_we during compute is dropped (read back via effect: gain unchanged). RST low mid-compute -> no out_valid, out_data=0, in_ready=1 next cycle, pass-through restored.

Source files
------------

// File: rtl/iir_sos_pkg.sv
// Shared types and helpers for the time-multiplexed biquad cascade.
// Holds the FSM state encoding, the coefficient slot indices and the saturating truncation.
package iir_sos_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_B0,
      ST_B1,
      ST_B2,
      ST_A1,
      ST_A2,
      ST_DONE
   } sos_state_t;

   localparam int COEF_PER_SEC = 5;
   localparam int K_B0 = 0;
   localparam int K_B1 = 1;
   localparam int K_B2 = 2;
   localparam int K_A1 = 3;
   localparam int K_A2 = 4;

   // Floor-shift by frac, then clamp to a dw-bit signed range.
   // Supports accumulators up to 64 bits and sample widths up to 32 bits.
   function automatic logic signed [31:0] sat_trunc(input logic signed [63:0] v,
                                                    input int frac, input int dw);
      logic signed [63:0] sh;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sh = v >>> frac;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (sh > hi)
         sh = hi;
      else if (sh < lo)
         sh = lo;
      return 32'(sh);
   endfunction

endpackage

// File: rtl/sos_sat_trunc.sv
// Converts an ACCW-bit accumulator with FRAC fractional bits into a saturated DW-bit sample.
module sos_sat_trunc
   import iir_sos_pkg::*;
#(
   parameter int ACCW = 36,
   parameter int DW   = 16,
   parameter int FRAC = 14
) (
   input  logic signed [ACCW-1:0] i_acc,
   output logic signed [DW-1:0]   o_y
);

   assign o_y = DW'(sat_trunc(64'(i_acc), FRAC, DW));

endmodule

// File: rtl/iir_sos_cascade.sv
// Cascade of NSEC transposed-DF-II biquads sharing one multiplier and one accumulator.
// Each section takes five cycles (b0, b1, b2, a1, a2), and a sample is accepted only when idle.
module iir_sos_cascade
   import iir_sos_pkg::*;
#(
   parameter int DW   = 16,
   parameter int CW   = 16,
   parameter int FRAC = 14,
   parameter int ACCW = 36,
   parameter int NSEC = 4,
   localparam int NCOEF = COEF_PER_SEC * NSEC,
   localparam int AW    = $clog2(NCOEF)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_data,
   output logic                 out_valid,
   output logic signed [DW-1:0] out_data,
   input  logic                 cfg_we,
   output logic                 cfg_ready,
   input  logic [AW-1:0]        cfg_addr,
   input  logic signed [CW-1:0] cfg_data,
   input  logic                 state_clr
);

   localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;

   sos_state_t               r_state, w_state_nxt;
   logic [SW-1:0]            r_sec;
   logic signed [DW-1:0]     r_x, r_y, r_out;
   logic signed [ACCW-1:0]   r_acc;
   logic signed [ACCW-1:0]   r_z1 [NSEC];
   logic signed [ACCW-1:0]   r_z2 [NSEC];
   logic signed [CW-1:0]     r_coef [NCOEF];

   logic [2:0]               w_k;
   logic [AW-1:0]            w_cidx;
   logic signed [DW-1:0]     w_opnd;
   logic signed [CW-1:0]     w_coef;
   logic signed [DW+CW-1:0]  w_prod;
   logic signed [ACCW-1:0]   w_pext, w_acc_b0;
   logic signed [DW-1:0]     w_y;
   logic                     w_last;

   always_comb begin
      w_k = 3'(K_B0);
      case (r_state)
         ST_B1:   w_k = 3'(K_B1);
         ST_B2:   w_k = 3'(K_B2);
         ST_A1:   w_k = 3'(K_A1);
         ST_A2:   w_k = 3'(K_A2);
         default: w_k = 3'(K_B0);
      endcase
   end

   assign w_cidx   = AW'(COEF_PER_SEC * int'(r_sec) + int'(w_k));
   assign w_opnd   = (r_state == ST_A1 || r_state == ST_A2) ? r_y : r_x;
   assign w_coef   = r_coef[w_cidx];
   assign w_prod   = w_opnd * w_coef;
   assign w_pext   = ACCW'(w_prod);
   assign w_acc_b0 = w_pext + r_z1[r_sec];
   assign w_last   = (r_sec == SW'(NSEC - 1));

   sos_sat_trunc #(.ACCW(ACCW), .DW(DW), .FRAC(FRAC)) u_sat (
      .i_acc (w_acc_b0),
      .o_y   (w_y)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid) w_state_nxt = ST_B0;
         ST_B0:   w_state_nxt = ST_B1;
         ST_B1:   w_state_nxt = ST_B2;
         ST_B2:   w_state_nxt = ST_A1;
         ST_A1:   w_state_nxt = ST_A2;
         ST_A2:   w_state_nxt = w_last ? ST_DONE : ST_B0;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // z2 doubles as the holding register for x*b2: the old z2 is consumed in B1 before B2 overwrites it.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_sec <= '0;
         r_x   <= '0;
         r_y   <= '0;
         r_acc <= '0;
         r_out <= '0;
         for (int i = 0; i < NSEC; i++) begin
            r_z1[i] <= '0;
            r_z2[i] <= '0;
         end
         for (int i = 0; i < NCOEF; i++) begin
            r_coef[i] <= '0;
            if (i % COEF_PER_SEC == K_B0) r_coef[i] <= CW'(1 << FRAC);
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cfg_we && int'(cfg_addr) < NCOEF) r_coef[cfg_addr] <= cfg_data;
               if (state_clr) begin
                  for (int i = 0; i < NSEC; i++) begin
                     r_z1[i] <= '0;
                     r_z2[i] <= '0;
                  end
               end
               if (in_valid) begin
                  r_x   <= in_data;
                  r_sec <= '0;
               end
            end
            ST_B0: r_y <= w_y;
            ST_B1: r_acc <= w_pext + r_z2[r_sec];
            ST_B2: r_z2[r_sec] <= w_pext;
            ST_A1: r_z1[r_sec] <= r_acc + w_pext;
            ST_A2: begin
               r_z2[r_sec] <= r_z2[r_sec] + w_pext;
               if (w_last) begin
                  r_out <= r_y;
               end else begin
                  r_sec <= r_sec + 1'b1;
                  r_x   <= r_y;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign cfg_ready = in_ready;
   assign out_valid = (r_state == ST_DONE);
   assign out_data  = r_out;

endmodule

// File: tb/tb_iir_sos_cascade.sv
// Bench for iir_sos_cascade: directed scenarios plus randomized samples and coefficients,
// checked against an arithmetic model of the cascade equations.
module tb_iir_sos_cascade;

   localparam int DW     = 16;
   localparam int CW     = 16;
   localparam int FRAC   = 14;
   localparam int ACCW   = 36;
   localparam int NSEC   = 4;
   localparam int NCOEF  = 5 * NSEC;
   localparam int AW     = $clog2(NCOEF);
   localparam int LAT    = 5 * NSEC + 1;
   localparam int PERIOD = 5 * NSEC + 2;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_data;
   logic                 out_valid;
   logic signed [DW-1:0] out_data;
   logic                 cfg_we;
   logic                 cfg_ready;
   logic [AW-1:0]        cfg_addr;
   logic signed [CW-1:0] cfg_data;
   logic                 state_clr;

   int n_vec = 0;
   int n_err = 0;

   int     mcoef [NCOEF];
   longint mz1 [NSEC];
   longint mz2 [NSEC];

   iir_sos_cascade #(.DW(DW), .CW(CW), .FRAC(FRAC), .ACCW(ACCW), .NSEC(NSEC)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .cfg_we    (cfg_we),
      .cfg_ready (cfg_ready),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .state_clr (state_clr)
   );

   always #5 CLK = ~CLK;

   function automatic longint wrapa(input longint v);
      return (v <<< (64 - ACCW)) >>> (64 - ACCW);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NCOEF; i++) mcoef[i] = (i % 5 == 0) ? (1 << FRAC) : 0;
      for (int s = 0; s < NSEC; s++) begin
         mz1[s] = 0;
         mz2[s] = 0;
      end
   endfunction

   function automatic void model_clear();
      for (int s = 0; s < NSEC; s++) begin
         mz1[s] = 0;
         mz2[s] = 0;
      end
   endfunction

   function automatic int model_step(input int x);
      longint xv, yv, acc, hi, lo;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -hi - 1;
      xv = x;
      for (int s = 0; s < NSEC; s++) begin
         acc = wrapa(xv * mcoef[5*s] + mz1[s]);
         yv  = acc >>> FRAC;
         if (yv > hi) yv = hi;
         else if (yv < lo) yv = lo;
         mz1[s] = wrapa(xv * mcoef[5*s+1] + yv * mcoef[5*s+3] + mz2[s]);
         mz2[s] = wrapa(xv * mcoef[5*s+2] + yv * mcoef[5*s+4]);
         xv = yv;
      end
      return int'(xv);
   endfunction

   task automatic do_reset();
      RST = 1'b0; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0;
      cfg_addr = '0; cfg_data = '0; state_clr = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b1;
      model_reset();
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic cfg_write(input int addr, input int data);
      bit ok;
      wait_idle(ok);
      cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = CW'(data);
      @(posedge CLK); #1;
      cfg_we = 1'b0;
      if (addr < NCOEF) mcoef[addr] = data;
   endtask

   // Waits for idle, hands over one sample, then waits (bounded) for its result.
   task automatic send(input int x, input bit clr, output int got, output int lat,
                       output bit ok, output bit rdy_bad);
      bit ok0;
      wait_idle(ok0);
      in_valid = 1'b1; in_data = DW'(x); state_clr = clr;
      @(posedge CLK); #1;
      in_valid = 1'b0; state_clr = 1'b0;
      lat = 1; rdy_bad = 1'b0; ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         if (in_ready) rdy_bad = 1'b1;
         @(posedge CLK); #1;
         lat++;
      end
      ok  = ok & ok0;
      got = int'(out_data);
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
   endtask

   task automatic test_passthrough();
      int got, lat; bit ok, rb;
      do_reset();
      send(1000, 1'b0, got, lat, ok, rb);
      n_vec++; if (!ok || got !== 1000) begin n_err++; $display("FAIL pass_data got=%0d want=1000 ok=%b", got, ok); end
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL pass_latency got=%0d want=%0d", lat, LAT); end
      n_vec++; if (rb !== 1'b0) begin n_err++; $display("FAIL pass_in_ready_busy got=%b want=0", rb); end
      send(-32768, 1'b0, got, lat, ok, rb);
      n_vec++; if (!ok || got !== -32768) begin n_err++; $display("FAIL pass_min got=%0d want=-32768", got); end
   endtask

   task automatic test_floor();
      int got, lat; bit ok, rb;
      do_reset();
      cfg_write(0, 8192);
      send(1000, 1'b0, got, lat, ok, rb);
      n_vec++; if (!ok || got !== 500) begin n_err++; $display("FAIL floor_pos got=%0d want=500", got); end
      send(-1001, 1'b0, got, lat, ok, rb);
      n_vec++; if (!ok || got !== -501) begin n_err++; $display("FAIL floor_neg got=%0d want=-501", got); end
   endtask

   task automatic test_saturation();
      int got, lat; bit ok, rb;
      do_reset();
      cfg_write(0, 24576);
      send(30000, 1'b0, got, lat, ok, rb);
      n_vec++; if (!ok || got !== 32767) begin n_err++; $display("FAIL sat_pos got=%0d want=32767", got); end
      send(-30000, 1'b0, got, lat, ok, rb);
      n_vec++; if (!ok || got !== -32768) begin n_err++; $display("FAIL sat_neg got=%0d want=-32768", got); end
   endtask

   task automatic test_pole_and_clr();
      int xs [4] = '{16384, 0, 0, 0};
      int ex [4] = '{16384, 8192, 4096, 2048};
      int got, lat; bit ok, rb;
      do_reset();
      cfg_write(0, 16384);
      cfg_write(3, 8192);
      for (int i = 0; i < 4; i++) begin
         send(xs[i], 1'b0, got, lat, ok, rb);
         n_vec++; if (!ok || got !== ex[i]) begin n_err++; $display("FAIL pole_%0d got=%0d want=%0d", i, got, ex[i]); end
      end
      send(0, 1'b1, got, lat, ok, rb);
      n_vec++; if (!ok || got !== 0) begin n_err++; $display("FAIL state_clr got=%0d want=0", got); end
   endtask

   task automatic test_unit_delay();
      int xs [3] = '{5000, 0, 0};
      int ex [3] = '{0, 5000, 0};
      int got, lat; bit ok, rb;
      do_reset();
      cfg_write(0, 0);
      cfg_write(1, 16384);
      for (int i = 0; i < 3; i++) begin
         send(xs[i], 1'b0, got, lat, ok, rb);
         n_vec++; if (!ok || got !== ex[i]) begin n_err++; $display("FAIL delay_%0d got=%0d want=%0d", i, got, ex[i]); end
      end
   endtask

   task automatic test_cfg_rules();
      int got, lat; bit ok, rb, seen;
      do_reset();
      // write in the same idle cycle as the handshake must already apply to that sample
      in_valid = 1'b1; in_data = DW'(1000);
      cfg_we = 1'b1; cfg_addr = AW'(0); cfg_data = CW'(8192);
      @(posedge CLK); #1;
      in_valid = 1'b0; cfg_we = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (out_valid) seen = 1'b1; else begin @(posedge CLK); #1; end
      end
      n_vec++; if (!seen || out_data !== 16'sd500) begin n_err++; $display("FAIL cfg_same_cycle got=%0d want=500", out_data); end
      // writes while busy are dropped
      do_reset();
      in_valid = 1'b1; in_data = DW'(1000);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      cfg_we = 1'b1; cfg_addr = AW'(0); cfg_data = CW'(8192);
      n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL cfg_ready_busy got=%b want=0", cfg_ready); end
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (out_valid) seen = 1'b1; else begin @(posedge CLK); #1; end
      end
      cfg_we = 1'b0;
      n_vec++; if (!seen || out_data !== 16'sd1000) begin n_err++; $display("FAIL busy_write_cur got=%0d want=1000", out_data); end
      send(1000, 1'b0, got, lat, ok, rb);
      n_vec++; if (!ok || got !== 1000) begin n_err++; $display("FAIL busy_write_next got=%0d want=1000", got); end
      // addresses beyond the coefficient file are ignored
      cfg_write(20, 8192);
      cfg_write(31, 0);
      send(1000, 1'b0, got, lat, ok, rb);
      n_vec++; if (!ok || got !== 1000) begin n_err++; $display("FAIL cfg_out_of_range got=%0d want=1000", got); end
   endtask

   task automatic test_abort();
      int got, lat; bit ok, rb, seen;
      do_reset();
      cfg_write(0, 8192);
      in_valid = 1'b1; in_data = DW'(1234);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      repeat (5) begin @(posedge CLK); #1; end
      RST = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b1;
      model_reset();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready got=%b want=1", in_ready); end
      n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL abort_out_data got=%0d want=0", out_data); end
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid) seen = 1'b1;
         @(posedge CLK); #1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got=%b want=0", seen); end
      send(777, 1'b0, got, lat, ok, rb);
      n_vec++; if (!ok || got !== 777) begin n_err++; $display("FAIL abort_passthru got=%0d want=777", got); end
   endtask

   task automatic test_random();
      int got, lat, x, ex; bit ok, rb, clr;
      do_reset();
      for (int s = 0; s < NSEC; s++) begin
         cfg_write(5*s + 0, int'($urandom_range(32767)) - 16384);
         cfg_write(5*s + 1, int'($urandom_range(32767)) - 16384);
         cfg_write(5*s + 2, int'($urandom_range(32767)) - 16384);
         cfg_write(5*s + 3, int'($urandom_range(24000)) - 12000);
         cfg_write(5*s + 4, int'($urandom_range(12000)) - 6000);
      end
      for (int i = 0; i < 40; i++) begin
         x   = int'($urandom_range(65535)) - 32768;
         clr = ($urandom_range(9) == 0);
         if (clr) model_clear();
         ex = model_step(x);
         send(x, clr, got, lat, ok, rb);
         n_vec++; if (!ok || got !== ex) begin n_err++; $display("FAIL random_%0d x=%0d got=%0d want=%0d", i, x, got, ex); end
      end
   endtask

   task automatic test_back_to_back();
      int xs [6];
      int exq [$];
      int gotq [$];
      int k, cyc, last;
      bit hs;
      for (int i = 0; i < 6; i++) xs[i] = int'($urandom_range(65535)) - 32768;
      k = 0; cyc = 0; last = -1;
      in_valid = 1'b1; in_data = DW'(xs[0]);
      while ((k < 6 || gotq.size() < 6) && cyc < 1000) begin
         hs = in_valid && in_ready;
         @(posedge CLK); #1;
         cyc++;
         if (out_valid) gotq.push_back(int'(out_data));
         if (hs) begin
            exq.push_back(model_step(xs[k]));
            if (last >= 0) begin
               n_vec++; if (cyc - last !== PERIOD) begin n_err++; $display("FAIL b2b_period got=%0d want=%0d", cyc - last, PERIOD); end
            end
            last = cyc;
            k++;
            if (k < 6) in_data = DW'(xs[k]); else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      n_vec++; if (gotq.size() !== 6) begin n_err++; $display("FAIL b2b_count got=%0d want=6", gotq.size()); end
      for (int i = 0; i < gotq.size() && i < exq.size(); i++) begin
         n_vec++; if (gotq[i] !== exq[i]) begin n_err++; $display("FAIL b2b_%0d got=%0d want=%0d", i, gotq[i], exq[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_floor();
      test_saturation();
      test_pole_and_clr();
      test_unit_delay();
      test_cfg_rules();
      test_abort();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
